filter_coef_sequencer: RTL and testbench
========================================

Name: filter_coef_sequencer

Overview:
- Control block between the sample source and the systolic symmetric FIR filter.
- Passes samples through to the filter and returns its outputs in normal operation.
- On a host commit it sequences a safe coefficient reload: drain the old pipeline, stream the new coefficient set from a shadow bank, flush the delay line with zeros, let those zeros settle, then resume.
- Samples arriving while the reload runs are dropped and counted. Invalid filter outputs are suppressed.

Parameters:
- DATA_W, 18, sample width in and out.
- COEF_W, 18, coefficient width.
- NUM_COEF, 16, number of unique coefficients (half of the symmetric taps).
- ADDR_W, 4, coefficient address width; 2**ADDR_W >= NUM_COEF.
- PIPE_LAT, 20, filter input-to-output latency in cycles.
- FLUSH_LEN, 32, number of zero samples needed to clear the delay line.

Ports:
- Clk_i, in, 1, clock; all logic is on the rising edge.
- Rst_i, in, 1, synchronous active-high reset.
- Data_i, in, DATA_W, upstream sample, signed.
- DataNd_i, in, 1, upstream new-data strobe.
- FiltData_o, out, DATA_W, sample to the filter.
- FiltDataNd_o, out, 1, new-data strobe to the filter.
- FiltData_i, in, DATA_W, filter output.
- FiltValid_i, in, 1, filter output valid.
- Data_o, out, DATA_W, returned filtered sample.
- DataValid_o, out, 1, returned sample valid.
- CoefWrEn_i, in, 1, shadow bank write enable.
- CoefAddr_i, in, ADDR_W, shadow bank write address.
- CoefData_i, in, COEF_W, shadow bank write data.
- Commit_i, in, 1, request a coefficient reload.
- FiltCoefWe_o, out, 1, coefficient write strobe to the filter.
- FiltCoefAddr_o, out, ADDR_W, coefficient address to the filter.
- FiltCoefData_o, out, COEF_W, coefficient data to the filter.
- Busy_o, out, 1, high whenever the FSM is not in RUN.
- DropCnt_o, out, 16, count of samples dropped while busy.

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to RUN.
  - The pending flag clears.
  - Shadow bank contents are not reset.
- All outputs are registered.
- States are RUN, DRAIN, LOAD, FLUSH and SETTLE. One phase counter is shared and reloaded on each state entry.
- RUN:
  - FiltDataNd_o <= DataNd_i and FiltData_o <= Data_i, so 1-cycle latency.
  - DataValid_o <= FiltValid_i and Data_o <= FiltData_i, so 1-cycle latency.
  - Shadow writes with CoefWrEn_i=1 and CoefAddr_i < NUM_COEF are stored. Addresses >= NUM_COEF are ignored.
- Commit sampled in RUN:
  - Next state is DRAIN and Busy_o=1 from the next cycle.
  - A sample with DataNd_i on the same edge is still forwarded.
- DRAIN (PIPE_LAT cycles):
  - FiltDataNd_o=0.
  - Filter outputs are still forwarded, since they are valid old-coefficient results.
- LOAD (NUM_COEF cycles):
  - FiltCoefWe_o=1 with FiltCoefAddr_o = 0,1,…,NUM_COEF-1, one per cycle in ascending order.
  - FiltCoefData_o = shadow[addr].
  - FiltCoefWe_o is 0 in every other state.
- FLUSH (FLUSH_LEN cycles): FiltDataNd_o=1 and FiltData_o=0.
- SETTLE (PIPE_LAT cycles): FiltDataNd_o=0.
- Output suppression: DataValid_o is forced to 0 in LOAD, FLUSH and SETTLE, and Data_o holds its last value.
- Busy window:
  - Total busy is PIPE_LAT+NUM_COEF+FLUSH_LEN+PIPE_LAT cycles, which is 88 at the defaults.
  - The state then returns to RUN and Busy_o falls.
- Drops:
  - Every DataNd_i=1 seen while Busy_o=1 is dropped and increments DropCnt_o.
  - DropCnt_o saturates at 65535 and is cleared only by reset.
- Shadow writes while Busy_o=1 are ignored, so the loaded set is always consistent.
- Commit while busy:
  - Sets a sticky pending flag; repeated commits while busy collapse into one.
  - On return to RUN, exactly one RUN cycle passes (passthrough active), then DRAIN starts again and pending clears.
- Reset mid-sequence:
  - Aborts immediately to RUN with all outputs 0 on the next cycle.
  - No further FiltCoefWe_o pulses are issued.
  - The filter may hold a partial coefficient set; upstream re-commits.

Test Plan:
- Passthrough: after reset, drive DataNd_i=1 with Data_i ramping 0,1,2…; return FiltData_i=0x1234 with FiltValid_i=1. Required: FiltData_o follows Data_i with 1-cycle lag; Data_o=0x1234 with DataValid_o=1 one cycle later; Busy_o=0 and DropCnt_o=0.
- Reload sequence: write shadow[i]=i*0x100 for i=0..15, then pulse Commit_i at cycle T. Required:
  - Busy_o=1 over T+1..T+88.
  - FiltCoefWe_o=1 over T+21..T+36, carrying addresses 0..15 and data 0x000..0xF00.
  - FiltDataNd_o=1 with FiltData_o=0 over T+37..T+68.
  - Passthrough resumes at T+89.
- Drop counting: hold DataNd_i=1 through the reload. Required: DropCnt_o=88 afterwards. Preset near saturation via a long run to check it holds at 65535.
- Output suppression: hold FiltValid_i=1 throughout. Required: DataValid_o=1 during DRAIN, 0 during LOAD/FLUSH/SETTLE, then 1 again in RUN.
- Commit while busy: pulse Commit_i 3 times during LOAD, and attempt a shadow write shadow[0]=0x3FFFF during FLUSH. Required: exactly one extra reload starts 1 RUN cycle after the first finishes, and its address-0 data is the old value, not 0x3FFFF.
- Reset mid-LOAD: assert Rst_i at the 5th LOAD cycle. Required: on the next cycle FiltCoefWe_o=0, Busy_o=0, DropCnt_o=0, and the state is RUN (passthrough works).

Source files
------------

// File: rtl/filter_coef_sequencer.sv
// filter_coef_sequencer: sample passthrough to a FIR with drained, flushed coefficient reload
module filter_coef_sequencer #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NUM_COEF  = 16,
  parameter int ADDR_W    = 4,
  parameter int PIPE_LAT  = 20,
  parameter int FLUSH_LEN = 32
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic              DataNd_i,
  output logic [DATA_W-1:0] FiltData_o,
  output logic              FiltDataNd_o,
  input  logic [DATA_W-1:0] FiltData_i,
  input  logic              FiltValid_i,
  output logic [DATA_W-1:0] Data_o,
  output logic              DataValid_o,
  input  logic              CoefWrEn_i,
  input  logic [ADDR_W-1:0] CoefAddr_i,
  input  logic [COEF_W-1:0] CoefData_i,
  input  logic              Commit_i,
  output logic              FiltCoefWe_o,
  output logic [ADDR_W-1:0] FiltCoefAddr_o,
  output logic [COEF_W-1:0] FiltCoefData_o,
  output logic              Busy_o,
  output logic [15:0]       DropCnt_o
);
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {RUN, DRAIN, LOAD, FLUSH, SETTLE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, len;
  logic [ADDR_W-1:0] addr_n;
  logic pending, pass_n;
  logic [COEF_W-1:0] shadow [NUM_COEF];
  always_comb begin
    len = state == LOAD ? CNT_W'(NUM_COEF) : state == FLUSH ? CNT_W'(FLUSH_LEN) : CNT_W'(PIPE_LAT);
    state_n = state;
    cnt_n = '0;
    if (state == RUN) state_n = (Commit_i || pending) ? DRAIN : RUN;
    else if (cnt == len - CNT_W'(1)) state_n = state == DRAIN ? LOAD : state == LOAD ? FLUSH : state == FLUSH ? SETTLE : RUN;
    else cnt_n = cnt + CNT_W'(1);
    addr_n = cnt_n[ADDR_W-1:0];
    pass_n = state_n == RUN || state_n == DRAIN;
  end
  // outputs are registered from the state being entered so they line up with Busy_o
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state <= RUN;
      cnt <= '0;
      pending <= 1'b0;
      FiltData_o <= '0;
      FiltDataNd_o <= 1'b0;
      Data_o <= '0;
      DataValid_o <= 1'b0;
      FiltCoefWe_o <= 1'b0;
      FiltCoefAddr_o <= '0;
      FiltCoefData_o <= '0;
      Busy_o <= 1'b0;
      DropCnt_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pending <= state == RUN ? 1'b0 : pending | Commit_i;
      Busy_o <= state_n != RUN;
      FiltDataNd_o <= state == RUN ? DataNd_i : state_n == FLUSH;
      FiltData_o <= state == RUN ? Data_i : state_n == FLUSH ? '0 : FiltData_o;
      DataValid_o <= pass_n && FiltValid_i;
      Data_o <= pass_n ? FiltData_i : Data_o;
      FiltCoefWe_o <= state_n == LOAD;
      FiltCoefAddr_o <= state_n == LOAD ? addr_n : FiltCoefAddr_o;
      FiltCoefData_o <= state_n == LOAD ? shadow[addr_n] : FiltCoefData_o;
      if (Busy_o && DataNd_i && DropCnt_o != 16'hFFFF) DropCnt_o <= DropCnt_o + 16'd1;
    end
  end
  always_ff @(posedge Clk_i)
    if (!Rst_i && state == RUN && CoefWrEn_i && {1'b0, CoefAddr_i} < (ADDR_W+1)'(NUM_COEF))
      shadow[CoefAddr_i] <= CoefData_i;
endmodule

// File: tb/tb_filter_coef_sequencer.sv
// tb_filter_coef_sequencer: directed + random stimulus against a cycle-count reference model
module tb_filter_coef_sequencer;
  localparam int DW = 18, CW = 18, NC = 16, AW = 4, PL = 20, FL = 32;
  localparam int L_BEG = PL, F_BEG = PL + NC, S_BEG = PL + NC + FL, BUSY = 2 * PL + NC + FL;
  logic clk = 0, rst = 0;
  logic [DW-1:0] data_i = '0, filt_data_i = '0;
  logic data_nd = 0, filt_valid = 0, coef_wr = 0, commit = 0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic [DW-1:0] filt_data_o, data_o;
  logic filt_nd_o, data_valid_o, coef_we_o, busy_o;
  logic [AW-1:0] coef_addr_o;
  logic [CW-1:0] coef_data_o;
  logic [15:0] drop_o;
  filter_coef_sequencer #(.DATA_W(DW), .COEF_W(CW), .NUM_COEF(NC), .ADDR_W(AW), .PIPE_LAT(PL), .FLUSH_LEN(FL)) dut (
    .Clk_i(clk), .Rst_i(rst), .Data_i(data_i), .DataNd_i(data_nd),
    .FiltData_o(filt_data_o), .FiltDataNd_o(filt_nd_o), .FiltData_i(filt_data_i), .FiltValid_i(filt_valid),
    .Data_o(data_o), .DataValid_o(data_valid_o), .CoefWrEn_i(coef_wr), .CoefAddr_i(coef_addr),
    .CoefData_i(coef_data), .Commit_i(commit), .FiltCoefWe_o(coef_we_o), .FiltCoefAddr_o(coef_addr_o),
    .FiltCoefData_o(coef_data_o), .Busy_o(busy_o), .DropCnt_o(drop_o));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  // reference model: a reload is "busy" for BUSY edges counted from the commit edge
  bit active = 0, pend = 0;
  int start = 0, drop = 0;
  logic [CW-1:0] sh [NC];
  logic [DW-1:0] e_fd = '0, e_do = '0;
  logic e_fnd = 0, e_dv = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [CW-1:0] e_data = '0;
  int we_rises = 0;
  logic prev_we = 0;
  logic [CW-1:0] rise_data [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic model_update();
    bit was_run;
    int p;
    cyc++;
    if (rst) begin
      active = 0; pend = 0; drop = 0;
      e_fd = '0; e_do = '0; e_fnd = 0; e_dv = 0; e_we = 0; e_addr = '0; e_data = '0;
    end else begin
      was_run = !active;
      if (was_run) begin
        e_fnd = data_nd;
        e_fd = data_i;
        if (coef_wr && int'(coef_addr) < NC) sh[coef_addr] = coef_data;
        if (commit || pend) begin active = 1; start = cyc; pend = 0; end
      end else begin
        if (data_nd && drop < 65535) drop++;
        if (commit) pend = 1;
      end
      p = cyc - start;
      if (active && p >= BUSY) active = 0;
      if (!was_run) begin
        e_fnd = active && p >= F_BEG && p < S_BEG;
        if (e_fnd) e_fd = '0;
      end
      e_we = active && p >= L_BEG && p < F_BEG;
      if (e_we) begin e_addr = AW'(p - L_BEG); e_data = sh[p - L_BEG]; end
      if (!active || p < L_BEG) begin e_dv = filt_valid; e_do = filt_data_i; end
      else e_dv = 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("FiltData_o", filt_data_o, e_fd);
    chk("FiltDataNd_o", filt_nd_o, e_fnd);
    chk("Data_o", data_o, e_do);
    chk("DataValid_o", data_valid_o, e_dv);
    chk("FiltCoefWe_o", coef_we_o, e_we);
    chk("FiltCoefAddr_o", coef_addr_o, e_addr);
    chk("FiltCoefData_o", coef_data_o, e_data);
    chk("Busy_o", busy_o, active);
    chk("DropCnt_o", drop_o, drop);
    if (coef_we_o && !prev_we) begin we_rises++; rise_data.push_back(coef_data_o); end
    prev_we = coef_we_o;
  endtask
  task automatic rand_in();
    data_i = DW'($urandom);
    data_nd = 1'($urandom);
    filt_data_i = DW'($urandom);
    filt_valid = 1'($urandom);
  endtask
  initial begin
    logic [CW-1:0] old0;
    int n;
    for (int i = 0; i < NC; i++) sh[i] = '0;
    rst = 1; tick(); tick(); rst = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_we", coef_we_o, 0);
    // passthrough ramp
    for (int i = 0; i < 10; i++) begin
      data_nd = 1; data_i = DW'(i); filt_data_i = DW'('h1234); filt_valid = 1;
      tick();
      chk("pt_fd", filt_data_o, i);
      chk("pt_do", data_o, 'h1234);
    end
    // shadow load i*0x100
    for (int i = 0; i < NC; i++) begin
      coef_wr = 1; coef_addr = AW'(i); coef_data = CW'(i * 'h100);
      tick();
    end
    coef_wr = 0;
    // reload with DataNd held high and FiltValid held high
    data_nd = 1; filt_valid = 1; commit = 1;
    tick();
    commit = 0;
    for (int j = 1; j <= BUSY; j++) begin
      data_i = DW'($urandom);
      filt_data_i = DW'($urandom);
      tick();
      if (j >= L_BEG && j < F_BEG) chk("load_data", coef_data_o, (j - L_BEG) * 'h100);
      if (j >= L_BEG && j < BUSY) chk("suppress", data_valid_o, 0);
    end
    chk("drop88", drop_o, BUSY);
    chk("busy_end", busy_o, 0);
    chk("resume_dv", data_valid_o, 1);
    // random traffic with random shadow writes and occasional commits
    for (int i = 0; i < 300; i++) begin
      rand_in();
      coef_wr = 1'($urandom); coef_addr = AW'($urandom); coef_data = CW'($urandom);
      commit = $urandom_range(0, 59) == 0;
      tick();
    end
    commit = 0; coef_wr = 0;
    n = 0;
    while ((active || pend) && n < 400) begin rand_in(); tick(); n++; end
    chk("idle_wait", n < 400, 1);
    // commit while busy, plus a shadow write attempt during FLUSH
    we_rises = 0; rise_data.delete();
    commit = 1; tick(); commit = 0;
    repeat (L_BEG + 2) begin rand_in(); tick(); end
    repeat (3) begin commit = 1; rand_in(); tick(); commit = 0; tick(); end
    repeat (10) begin rand_in(); tick(); end
    old0 = sh[0];
    coef_wr = 1; coef_addr = '0; coef_data = CW'('h3FFFF); tick(); coef_wr = 0;
    repeat (2 * BUSY) begin rand_in(); tick(); end
    chk("reloads", we_rises, 2);
    chk("second_addr0", rise_data.size() == 2 ? rise_data[1] : 'x, old0);
    // reset at the 5th LOAD cycle
    commit = 1; tick(); commit = 0;
    repeat (L_BEG + 4) begin data_nd = 1; tick(); end
    chk("mid_load_we", coef_we_o, 1);
    rst = 1; tick(); rst = 0;
    chk("rst_mid_we", coef_we_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_drop", drop_o, 0);
    data_nd = 1; data_i = DW'('h2A5A5); tick();
    chk("rst_mid_pt", filt_data_o, 'h2A5A5);
    chk("rst_mid_nd", filt_nd_o, 1);
    repeat (NC) begin data_nd = 0; tick(); end
    // back-to-back reloads until the drop counter saturates
    data_nd = 1; commit = 1; n = 0;
    while (drop < 65535 && n < 70000) begin tick(); n++; end
    chk("sat_reached", n < 70000, 1);
    repeat (200) tick();
    commit = 0;
    chk("sat_hold", drop_o, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
